// File: rtl/ksa_pipe.sv
// Pipelined Kogge-Stone adder/subtractor (s = a + b + cin, or s = a - b when sub=1), modulo 2^N with carry-out.
// Latency: PIPE_ALL ? $clog2(N)+2 : 2 cycles from accept to out_valid; one beat per cycle when unstalled.
// Backpressure: global stall, in_ready = !out_valid || out_ready; every stage holds while stalled. Optional KSA_PIPE_FLAGS_EN adds ovf/zero outputs.
module ksa_pipe #(
    parameter int N        = 32,
    parameter int PIPE_ALL = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         cout
`ifdef KSA_PIPE_FLAGS_EN
    ,
    output logic         ovf,
    output logic         zero
`endif
);

    localparam int LV = $clog2(N);

    // One radix-2 prefix level of span 2^(r-1). The carry-in is treated as an
    // extra generate below bit 0 with propagate 0, so gray cells (whose group
    // reaches down to the carry-in) produce P=0. That keeps P[N-1] meaningful
    // only when the top bit never reaches the carry-in inside the tree, which
    // is exactly the case the cout term P[N-1]&c0 has to cover.
    function automatic logic [2*N-1:0] prefix_level(input logic [N-1:0] p,
                                                    input logic [N-1:0] g,
                                                    input logic         c0,
                                                    input int           r);
        logic [N-1:0] pn;
        logic [N-1:0] gn;
        int           d;
        d = 1 << (r - 1);
        for (int i = 0; i < N; i++) begin
            if (i >= 2 * d - 1) begin
                gn[i] = g[i] | (p[i] & g[i-d]);
                pn[i] = p[i] & p[i-d];
            end else if (i == d - 1) begin
                gn[i] = g[i] | (p[i] & c0);
                pn[i] = 1'b0;
            end else if (i >= d) begin
                gn[i] = g[i] | (p[i] & g[i-d]);
                pn[i] = 1'b0;
            end else begin
                gn[i] = g[i];
                pn[i] = p[i];
            end
        end
        return {pn, gn};
    endfunction

    logic         adv;
    logic [N-1:0] bb;
    logic         c0;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign bb       = sub ? ~b : b;
    assign c0       = sub ? 1'b1 : cin;

    // Stage 0: operand conditioning and bitwise propagate/generate.
    logic         s0_v;
    logic [N-1:0] s0_p;
    logic [N-1:0] s0_g;
    logic         s0_c0;
`ifdef KSA_PIPE_FLAGS_EN
    logic         s0_sa;
`endif

    // Capture a new beat (or a bubble) whenever the pipeline advances.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s0_v <= 1'b0;
        end else if (adv) begin
            s0_v  <= in_valid;
            s0_p  <= a ^ bb;
            s0_g  <= a & bb;
            s0_c0 <= c0;
`ifdef KSA_PIPE_FLAGS_EN
            s0_sa <= a[N-1];
`endif
        end
    end

    // Tail of the prefix tree, seen by the sum stage.
    logic         t_v;
    logic [N-1:0] t_p;
    logic [N-1:0] t_g;
    logic [N-1:0] t_p0;
    logic         t_c0;
`ifdef KSA_PIPE_FLAGS_EN
    logic         t_sa;
`endif

    if (PIPE_ALL != 0) begin : g_pipe
        logic [LV:1]        q_v;
        logic [LV:1][N-1:0] q_p;
        logic [LV:1][N-1:0] q_g;
        logic [LV:1][N-1:0] q_p0;
        logic [LV:1]        q_c0;
`ifdef KSA_PIPE_FLAGS_EN
        logic [LV:1]        q_sa;
`endif

        // One register bank per prefix level; p0/c0 ride alongside the tree.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                q_v <= '0;
            end else if (adv) begin
                q_v[1]            <= s0_v;
                {q_p[1], q_g[1]}  <= prefix_level(s0_p, s0_g, s0_c0, 1);
                q_p0[1]           <= s0_p;
                q_c0[1]           <= s0_c0;
`ifdef KSA_PIPE_FLAGS_EN
                q_sa[1]           <= s0_sa;
`endif
                for (int r = 2; r <= LV; r++) begin
                    q_v[r]           <= q_v[r-1];
                    {q_p[r], q_g[r]} <= prefix_level(q_p[r-1], q_g[r-1], q_c0[r-1], r);
                    q_p0[r]          <= q_p0[r-1];
                    q_c0[r]          <= q_c0[r-1];
`ifdef KSA_PIPE_FLAGS_EN
                    q_sa[r]          <= q_sa[r-1];
`endif
                end
            end
        end

        assign t_v  = q_v[LV];
        assign t_p  = q_p[LV];
        assign t_g  = q_g[LV];
        assign t_p0 = q_p0[LV];
        assign t_c0 = q_c0[LV];
`ifdef KSA_PIPE_FLAGS_EN
        assign t_sa = q_sa[LV];
`endif
    end else begin : g_flat
        // Whole prefix tree in one combinational stretch between the two registers.
        always_comb begin
            t_p = s0_p;
            t_g = s0_g;
            for (int r = 1; r <= LV; r++) begin
                {t_p, t_g} = prefix_level(t_p, t_g, s0_c0, r);
            end
        end

        assign t_v  = s0_v;
        assign t_p0 = s0_p;
        assign t_c0 = s0_c0;
`ifdef KSA_PIPE_FLAGS_EN
        assign t_sa = s0_sa;
`endif
    end

    // Sum stage: bit i combines its own propagate with the carry into it.
    logic [N-1:0] sum_s;
    logic         sum_co;

    assign sum_s  = t_p0 ^ {t_g[N-2:0], t_c0};
    assign sum_co = t_g[N-1] | (t_p[N-1] & t_c0);

    // Output register; holds result and flags stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            s         <= '0;
            cout      <= 1'b0;
`ifdef KSA_PIPE_FLAGS_EN
            ovf       <= 1'b0;
            zero      <= 1'b0;
`endif
        end else if (adv) begin
            out_valid <= t_v;
            s         <= sum_s;
            cout      <= sum_co;
`ifdef KSA_PIPE_FLAGS_EN
            // Operand signs agree exactly when the top propagate bit is clear.
            ovf       <= !t_p0[N-1] && (sum_s[N-1] != t_sa);
            zero      <= (sum_s == '0);
`endif
        end
    end

endmodule

// File: tb/tb_ksa_pipe.sv
// Bench for ksa_pipe: DUT0 is N=8 with a register after every level, DUT1 is N=13 with input/output registers only.
// A plain-arithmetic model fills a queue per DUT on every accepted beat; a negedge process checks every valid output against it.
// Directed literal vectors pin latency and results; then backpressure, mid-flight reset and a long random run.
module tb_ksa_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  iv;
    logic [1:0]  ordy;
    logic [1:0]  cin_t;
    logic [1:0]  sub_t;
    logic [12:0] a_t [2];
    logic [12:0] b_t [2];

    logic        ir0, ir1, ov0, ov1, co0, co1;
    logic [7:0]  s0;
    logic [12:0] s1;
    logic [1:0]  ir, ov, co;
    logic [12:0] s_t [2];
`ifdef KSA_PIPE_FLAGS_EN
    logic        fo0, fo1, fz0, fz1;
    logic [1:0]  fo, fz;
    assign fo = {fo1, fo0};
    assign fz = {fz1, fz0};
`endif

    assign ir     = {ir1, ir0};
    assign ov     = {ov1, ov0};
    assign co     = {co1, co0};
    assign s_t[0] = {5'b0, s0};
    assign s_t[1] = s1;

    always #5 clk = ~clk;

    ksa_pipe #(.N(8), .PIPE_ALL(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir0),
        .a(a_t[0][7:0]), .b(b_t[0][7:0]), .cin(cin_t[0]), .sub(sub_t[0]),
        .out_valid(ov0), .out_ready(ordy[0]), .s(s0), .cout(co0)
`ifdef KSA_PIPE_FLAGS_EN
        , .ovf(fo0), .zero(fz0)
`endif
    );

    ksa_pipe #(.N(13), .PIPE_ALL(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir1),
        .a(a_t[1]), .b(b_t[1]), .cin(cin_t[1]), .sub(sub_t[1]),
        .out_valid(ov1), .out_ready(ordy[1]), .s(s1), .cout(co1)
`ifdef KSA_PIPE_FLAGS_EN
        , .ovf(fo1), .zero(fz1)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;
    int n_emit [2];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Result layout: [12:0] s, [13] cout, [14] signed overflow, [15] zero.
    function automatic logic [15:0] model(input int n, input logic [12:0] av, input logic [12:0] bv,
                                          input logic ci, input logic sb);
        longint m, ua, ub, r, hi, sa, sbv, sr;
        logic [15:0] res;
        m   = (longint'(1) << n) - 1;
        hi  = longint'(1) << (n - 1);
        ua  = longint'(av) & m;
        ub  = longint'(bv) & m;
        sa  = (ua >= hi) ? ua - 2 * hi : ua;
        sbv = (ub >= hi) ? ub - 2 * hi : ub;
        if (sb) begin
            r      = ua - ub;
            res[13] = (ua >= ub);
            sr     = sa - sbv;
        end else begin
            r      = ua + ub + longint'(ci);
            res[13] = (r > m);
            sr     = sa + sbv + longint'(ci);
        end
        res[12:0] = 13'(r & m);
        res[14]   = (sr >= hi) || (sr < -hi);
        res[15]   = ((r & m) == 0);
        return res;
    endfunction

    logic [15:0] q0 [$];
    logic [15:0] q1 [$];
    logic [15:0] mon_got, mon_exp;
    logic        mon_empty;

    // Scoreboard: inputs and outputs are stable at the negedge and are what the next posedge uses.
    always @(negedge clk) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
        end else begin
            for (int k = 0; k < 2; k++) begin
                check("in_ready rule", {31'b0, ir[k]}, {31'b0, (!ov[k] || ordy[k])});
                if (ov[k]) begin
                    mon_empty = (k == 0) ? (q0.size() == 0) : (q1.size() == 0);
                    check("output with no beat pending", {31'b0, mon_empty}, 32'd0);
                    if (!mon_empty) begin
                        mon_exp = (k == 0) ? q0[0] : q1[0];
`ifdef KSA_PIPE_FLAGS_EN
                        mon_got = {fz[k], fo[k], co[k], s_t[k]};
`else
                        mon_got = {2'b0, co[k], s_t[k]};
                        mon_exp = mon_exp & 16'h3FFF;
`endif
                        check(k == 0 ? "dut0 result" : "dut1 result", {16'b0, mon_got}, {16'b0, mon_exp});
                        if (ordy[k]) begin
                            if (k == 0) void'(q0.pop_front());
                            else        void'(q1.pop_front());
                            n_emit[k]++;
                        end
                    end
                end
                if (iv[k] && ir[k]) begin
                    if (k == 0) q0.push_back(model(8, a_t[0], b_t[0], cin_t[0], sub_t[0]));
                    else        q1.push_back(model(13, a_t[1], b_t[1], cin_t[1], sub_t[1]));
                end
            end
        end
    end

    // Single beat with literal expectations on latency, sum and carry.
    task automatic dir_beat(input int k, input logic [12:0] av, input logic [12:0] bv, input logic ci,
                            input logic sb, input logic [12:0] es, input logic eco, input int lat);
        int cnt;
        @(posedge clk); #1;
        iv[k] = 1'b1; a_t[k] = av; b_t[k] = bv; cin_t[k] = ci; sub_t[k] = sb; ordy[k] = 1'b1;
        @(posedge clk); #1;
        iv[k] = 1'b0;
        cnt = 1;
        while (!ov[k] && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("latency", cnt, lat);
        check("s literal", {19'b0, s_t[k]}, {19'b0, es});
        check("cout literal", {31'b0, co[k]}, {31'b0, eco});
    endtask

    localparam int NB = 10000;
    int          sent [2];
    logic [1:0]  accd;
    int          cyc, i, c, e0;
    logic        acc;

    initial begin
        rst_n = 1'b0; iv = '0; ordy = 2'b11; cin_t = '0; sub_t = '0;
        a_t[0] = '0; a_t[1] = '0; b_t[0] = '0; b_t[1] = '0;
        n_emit[0] = 0; n_emit[1] = 0;

        // Reset state
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            check("reset out_valid", {31'b0, ov[k]}, 32'd0);
            check("reset s", {19'b0, s_t[k]}, 32'd0);
            check("reset cout", {31'b0, co[k]}, 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) check("in_ready after reset", {31'b0, ir[k]}, 32'd1);

        // Directed vectors, N=8 PIPE_ALL=1 (latency 5)
        dir_beat(0, 13'h7F, 13'h01, 1'b0, 1'b0, 13'h80, 1'b0, 5);
`ifdef KSA_PIPE_FLAGS_EN
        check("ovf 7F+01", {31'b0, fo0}, 32'd1);
        check("zero 7F+01", {31'b0, fz0}, 32'd0);
`endif
        dir_beat(0, 13'h05, 13'h07, 1'b1, 1'b1, 13'hFE, 1'b0, 5);
        dir_beat(0, 13'h3C, 13'h3C, 1'b0, 1'b1, 13'h00, 1'b1, 5);
`ifdef KSA_PIPE_FLAGS_EN
        check("zero 3C-3C", {31'b0, fz0}, 32'd1);
`endif
        dir_beat(0, 13'hFF, 13'h00, 1'b1, 1'b0, 13'h00, 1'b1, 5);
        dir_beat(0, 13'hA5, 13'h5A, 1'b1, 1'b0, 13'h00, 1'b1, 5);
        dir_beat(0, 13'h12, 13'h34, 1'b0, 1'b0, 13'h46, 1'b0, 5);

        // Directed vectors, N=13 PIPE_ALL=0 (latency 2)
        dir_beat(1, 13'h1FFF, 13'h0000, 1'b1, 1'b0, 13'h0000, 1'b1, 2);
        dir_beat(1, 13'h0003, 13'h0005, 1'b0, 1'b1, 13'h1FFE, 1'b0, 2);
        dir_beat(1, 13'h0FFF, 13'h0001, 1'b0, 1'b0, 13'h1000, 1'b0, 2);

        // Backpressure: 10 beats on DUT0, consumer stalls for 3 cycles mid-stream
        e0 = n_emit[0];
        @(posedge clk); #1;
        iv[0] = 1'b1; a_t[0] = 13'($urandom_range(255, 0)); b_t[0] = 13'($urandom_range(255, 0));
        cin_t[0] = 1'($urandom_range(1, 0)); sub_t[0] = 1'b0;
        i = 0; c = 0;
        while (i < 10 && c < 100) begin
            ordy[0] = !(c >= 6 && c <= 8);
            @(negedge clk);
            if (c >= 6 && c <= 8) begin
                check("stall out_valid", {31'b0, ov[0]}, 32'd1);
                check("stall in_ready", {31'b0, ir[0]}, 32'd0);
            end
            acc = iv[0] && ir[0];
            @(posedge clk); #1;
            c++;
            if (acc) begin
                i++;
                if (i < 10) begin
                    a_t[0] = 13'($urandom_range(255, 0)); b_t[0] = 13'($urandom_range(255, 0));
                    cin_t[0] = 1'($urandom_range(1, 0));
                end else begin
                    iv[0] = 1'b0;
                end
            end
        end
        ordy[0] = 1'b1;
        check("backpressure beats accepted", i, 10);
        c = 0;
        while (q0.size() != 0 && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        check("backpressure drained", q0.size(), 0);
        check("backpressure emitted", n_emit[0] - e0, 10);

        // Reset with three beats in flight
        e0 = n_emit[0];
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            iv[0] = 1'b1; a_t[0] = 13'(8'h10 + k); b_t[0] = 13'h01; cin_t[0] = 1'b0; sub_t[0] = 1'b0;
        end
        @(posedge clk); #1;
        iv[0] = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("out_valid after mid reset", {31'b0, ov[0]}, 32'd0);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("no emit after mid reset", {31'b0, ov[0]}, 32'd0);
        end
        check("flushed beats never emitted", n_emit[0] - e0, 0);

        // Random traffic on both DUTs, valid held until accepted
        sent[0] = 0; sent[1] = 0; accd = '0; cyc = 0;
        e0 = n_emit[0];
        c  = n_emit[1];
        while ((sent[0] < NB || sent[1] < NB) && cyc < 70000) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                accd[k] = iv[k] && ir[k];
                if (accd[k]) sent[k]++;
            end
            @(posedge clk); #1;
            cyc++;
            for (int k = 0; k < 2; k++) begin
                if (!iv[k] || accd[k]) begin
                    iv[k]    = (sent[k] < NB) && ($urandom_range(1, 0) == 1);
                    a_t[k]   = 13'($urandom_range(8191, 0));
                    b_t[k]   = 13'($urandom_range(8191, 0));
                    cin_t[k] = 1'($urandom_range(1, 0));
                    sub_t[k] = 1'($urandom_range(1, 0));
                end
                ordy[k] = 1'($urandom_range(1, 0));
            end
        end
        check("random phase within budget", {31'b0, (cyc < 70000)}, 32'd1);
        iv = '0; ordy = 2'b11;
        cyc = 0;
        while ((q0.size() != 0 || q1.size() != 0) && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("random dut0 drained", q0.size(), 0);
        check("random dut1 drained", q1.size(), 0);
        check("random dut0 emitted", n_emit[0] - e0, NB);
        check("random dut1 emitted", n_emit[1] - c, NB);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
